ram_write_arbiter: RTL and testbench
====================================

// Module: ram_write_arbiter
// PURPOSE
//  Front-end controller for the 2-port RAM (sync write port, async read port).
//  After reset it sequences a full clear of the RAM. It then shares the single
//  write port between two requesters using round-robin arbitration with a
//  valid/ready handshake. All RAM write-port signals are driven from registers.
//  The RAM read port is not touched by this block.
// PARAMETERS
//  data_width     8   width of the RAM word and of reqN_data
//  address_width  7   RAM address width; depth = 2**address_width
//  INIT_VALUE     0   word written to every address during the clear sequence
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  req0_valid  in   1   requester 0 has a write pending
//  req0_addr   in   AW  requester 0 write address
//  req0_data   in   DW  requester 0 write data
//  req0_ready  out  1   requester 0 write accepted this cycle
//  req1_valid  in   1   requester 1 has a write pending
//  req1_addr   in   AW  requester 1 write address
//  req1_data   in   DW  requester 1 write data
//  req1_ready  out  1   requester 1 write accepted this cycle
//  init_done   out  1   clear sequence finished; arbitration is live
//  ram_we      out  1   to RAM we (registered)
//  ram_add_w   out  AW  to RAM add_w (registered)
//  ram_data_w  out  DW  to RAM data_w (registered)
// BEHAVIOUR
//  Reset (async, immediate): state=INIT, cnt=0, rr_ptr=0, init_done=0, ram_we=0,
//   ram_add_w=0, ram_data_w=0. A registered write that is in flight is dropped.
//  FSM has two states: INIT and RUN. No other transitions exist.
//  INIT: both readies are 0. On every posedge: ram_we<=1, ram_add_w<=cnt,
//   ram_data_w<=INIT_VALUE, cnt<=cnt+1.
//   When cnt==2**AW-1: state<=RUN and init_done<=1. cnt never wraps.
//   The sequence is exactly 2**AW consecutive writes, addresses 0..2**AW-1 in
//   ascending order. The RAM commits each write one edge after it is registered.
//  RUN: grant logic is combinational.
//   - If only one requester is valid, that requester is granted.
//   - If both are valid, the requester selected by rr_ptr is granted
//     (rr_ptr=0 selects req0, rr_ptr=1 selects req1).
//   - reqN_ready = (state==RUN) & granted_N. At most one ready is high per cycle.
//   - ready may depend combinationally on either valid.
//  Transfer: occurs when reqN_valid & reqN_ready at a posedge. On that edge:
//   - ram_we<=1, ram_add_w<=reqN_addr, ram_data_w<=reqN_data.
//   - rr_ptr<=~N, so the other requester has priority next time.
//  No transfer: ram_we<=0; ram_add_w and ram_data_w hold their values; rr_ptr holds.
//  Latency: acceptance at edge N -> RAM write at edge N+1.
//   Throughput is one write per cycle. Writes commit in acceptance order.
//  Same address from both requesters: the later-accepted write wins.
//   No merging or reordering is performed.
//  Requesters must hold valid/addr/data stable until ready is seen.
//   Requests made during INIT wait; they are served from the first RUN cycle.
//  Reset mid-INIT or mid-RUN: outputs go to reset values at once. The clear
//   sequence restarts at address 0. Unaccepted requests are not lost at the
//   requester side (they are still held stable).
// TESTING (defaults: DW=8, AW=7)
//  1 Release reset, both valid=0 -> ram_we=1 for exactly 128 cycles,
//    ram_add_w=0..127, ram_data_w=0x00; init_done=1 after 128th edge; readies 0.
//  2 After init, req0 valid addr=5 data=0xA5 -> req0_ready=1 same cycle;
//    next cycle ram_we=1, ram_add_w=5, ram_data_w=0xA5; RAM data_r@5=0xA5.
//  3 Both valid constantly (req0 addr=1/0x11, req1 addr=2/0x22) -> grants
//    alternate req0,req1,req0,...; ram_add_w alternates 1,2,1,... every cycle.
//  4 Both valid to addr=9 (req0 0x33, req1 0x44), rr_ptr=0 -> req0 first,
//    req1 next; final RAM data_r@9=0x44.
//  5 rst pulse at cnt=40 in INIT, and again mid-RUN -> ram_we=0 and init_done=0
//    immediately; clear restarts at address 0 and runs a full 128 writes.
//  6 req1 valid (addr=3, 0x5C) held from reset -> req1_ready=0 throughout INIT;
//    accepted on first cycle with init_done=1; RAM data_r@3=0x5C.

Source files
------------

// File: rtl/ram_write_arbiter_if.sv
// ram_write_arbiter_if
//   Bundles the two requester handshakes and the RAM write-port bus of the
//   write arbiter.
//   Parameters: DW (data width), AW (address width).
//   slave  modport : arbiter side (takes requests, drives readies and RAM bus)
//   master modport : requester/RAM side (drives requests, observes the rest)
interface ram_write_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 7
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          init_done;
  logic          ram_we;
  logic [AW-1:0] ram_add_w;
  logic [DW-1:0] ram_data_w;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, init_done,
    output ram_we, ram_add_w, ram_data_w
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, init_done,
    input  ram_we, ram_add_w, ram_data_w
  );
endinterface

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Front-end for a 2-port RAM write port. After reset it writes INIT_VALUE
//   to every address (0 .. 2**address_width-1, ascending), then shares the
//   write port between two requesters with round-robin arbitration.
//   All RAM write-port outputs are registered; a request accepted on edge N
//   appears on the RAM bus after edge N and commits in the RAM on edge N+1.
// Ports
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset
//   bus  : ram_write_arbiter_if.slave
//          req{0,1}_valid/addr/data in, req{0,1}_ready out (combinational),
//          init_done, ram_we, ram_add_w, ram_data_w out (registered)
module ram_write_arbiter #(
  parameter int                    data_width    = 8,
  parameter int                    address_width = 7,
  parameter logic [data_width-1:0] INIT_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_write_arbiter_if.slave   bus
);

  localparam int NUM_REQ = 2;
  localparam int AW      = address_width;
  localparam int DW      = data_width;
  localparam logic [AW-1:0] CNT_MAX = '1;

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          rr_q;        // 0: req0 has priority on a tie, 1: req1
  logic          init_done_q;
  logic          we_q;
  logic [AW-1:0] add_q;
  logic [DW-1:0] data_q;

  logic [NUM_REQ-1:0]         vld;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0][AW-1:0] req_addr;
  logic [NUM_REQ-1:0][DW-1:0] req_data;
  logic                       sel;
  logic [AW-1:0]              cnt_d;

  assign vld      = {bus.req1_valid, bus.req0_valid};
  assign req_addr = {bus.req1_addr,  bus.req0_addr};
  assign req_data = {bus.req1_data,  bus.req0_data};

  // Grant only while running; a lone requester always wins, a tie goes to
  // the requester rr_q points at.
  always_comb begin
    gnt = '0;
    if (state_q == RUN) begin
      if (vld[0] && (!vld[1] || !rr_q)) gnt[0] = 1'b1;
      else if (vld[1])                  gnt[1] = 1'b1;
    end
  end

  // gnt is one-hot or zero, so the high bit alone picks the winner.
  assign sel   = gnt[1];
  assign cnt_d = cnt_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      we_q        <= 1'b0;
      add_q       <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          we_q   <= 1'b1;
          add_q  <= cnt_q;
          data_q <= INIT_VALUE;
          // Counter stops on the last address instead of wrapping.
          if (cnt_q == CNT_MAX) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RUN: begin
          if (|gnt) begin
            we_q   <= 1'b1;
            add_q  <= req_addr[sel];
            data_q <= req_data[sel];
            rr_q   <= ~sel;       // the loser gets priority next time
          end else begin
            we_q   <= 1'b0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.init_done  = init_done_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_add_w  = add_q;
  assign bus.ram_data_w = data_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_write_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  ram_write_arbiter #(.data_width(DW), .address_width(AW), .INIT_VALUE(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, asynchronous read. ram_fill poisons it so
  // the clear sequence has something visible to overwrite.
  logic [DW-1:0] mem [DEPTH];
  logic          ram_fill = 1'b0;
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else if (bus.ram_we) begin
      mem[bus.ram_add_w] <= bus.ram_data_w;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    ram_fill = 1'b1;
    @(posedge clk); #1;
    ram_fill = 1'b0;
    n_cmp++;
    if ({bus.ram_we, bus.init_done, bus.req0_ready, bus.req1_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: we/done/rdy0/rdy1=%b%b%b%b want 0000",
               bus.ram_we, bus.init_done, bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if (bus.ram_add_w !== 7'd0 || bus.ram_data_w !== 8'h00) begin
      n_err++;
      $display("FAIL reset_bus: add=%0d data=%h want 0 00", bus.ram_add_w, bus.ram_data_w);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_clear();
    int nz;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ram_we !== 1'b1 || bus.ram_add_w !== AW'(i) || bus.ram_data_w !== 8'h00 ||
          bus.init_done !== (i == DEPTH-1)) begin
        n_err++;
        $display("FAIL init_clear[%0d]: we=%b add=%0d data=%h done=%b want 1 %0d 00 %b",
                 i, bus.ram_we, bus.ram_add_w, bus.ram_data_w, bus.init_done, i, (i == DEPTH-1));
      end
      n_cmp++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL init_ready[%0d]: rdy0=%b rdy1=%b want 0 0", i, bus.req0_ready, bus.req1_ready);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0 || bus.init_done !== 1'b1) begin
      n_err++;
      $display("FAIL init_end: we=%b done=%b want 0 1", bus.ram_we, bus.init_done);
    end
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) nz++;
    n_cmp++;
    if (nz != 0) begin
      n_err++;
      $display("FAIL init_ram: nonzero words=%0d want 0", nz);
    end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 7'd5; bus.req0_data = 8'hA5;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_ready: rdy0=%b rdy1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    idle();
    n_cmp++;
    if (bus.ram_we !== 1'b1 || bus.ram_add_w !== 7'd5 || bus.ram_data_w !== 8'hA5) begin
      n_err++;
      $display("FAIL single_bus: we=%b add=%0d data=%h want 1 5 a5", bus.ram_we, bus.ram_add_w, bus.ram_data_w);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[5] !== 8'hA5 || bus.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_ram: mem[5]=%h we=%b want a5 0", mem[5], bus.ram_we);
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    // Lone req1 write moves priority back to req0.
    bus.req1_valid = 1'b1; bus.req1_addr = 7'd10; bus.req1_data = 8'h77;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_err++;
      $display("FAIL alt_prep: rdy0=%b rdy1=%b want 0 1", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_addr = 7'd1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 7'd2; bus.req1_data = 8'h22;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (bus.req0_ready !== (k % 2 == 0) || bus.req1_ready !== (k % 2 == 1)) begin
        n_err++;
        $display("FAIL alt_ready[%0d]: rdy0=%b rdy1=%b want %b %b",
                 k, bus.req0_ready, bus.req1_ready, (k % 2 == 0), (k % 2 == 1));
      end
      @(posedge clk); #1;
      ea = (k % 2 == 0) ? 7'd1 : 7'd2;
      ed = (k % 2 == 0) ? 8'h11 : 8'h22;
      n_cmp++;
      if (bus.ram_we !== 1'b1 || bus.ram_add_w !== ea || bus.ram_data_w !== ed) begin
        n_err++;
        $display("FAIL alt_bus[%0d]: we=%b add=%0d data=%h want 1 %0d %h",
                 k, bus.ram_we, bus.ram_add_w, bus.ram_data_w, ea, ed);
      end
    end
    idle();
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0 || mem[1] !== 8'h11 || mem[2] !== 8'h22 || mem[10] !== 8'h77) begin
      n_err++;
      $display("FAIL alt_ram: we=%b m1=%h m2=%h m10=%h want 0 11 22 77",
               bus.ram_we, mem[1], mem[2], mem[10]);
    end
  endtask

  task automatic test_same_addr();
    bus.req0_valid = 1'b1; bus.req0_addr = 7'd9; bus.req0_data = 8'h33;
    bus.req1_valid = 1'b1; bus.req1_addr = 7'd9; bus.req1_data = 8'h44;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL same_first: rdy0=%b rdy1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_cmp++;
    if (bus.ram_add_w !== 7'd9 || bus.ram_data_w !== 8'h33) begin
      n_err++;
      $display("FAIL same_bus0: add=%0d data=%h want 9 33", bus.ram_add_w, bus.ram_data_w);
    end
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL same_second: rdy1=%b want 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    n_cmp++;
    if (bus.ram_data_w !== 8'h44 || mem[9] !== 8'h33) begin
      n_err++;
      $display("FAIL same_bus1: data=%h mem[9]=%h want 44 33", bus.ram_data_w, mem[9]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[9] !== 8'h44 || bus.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL same_ram: mem[9]=%h we=%b want 44 0", mem[9], bus.ram_we);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.req0_valid = 1'b1; bus.req0_addr = 7'd20; bus.req0_data = 8'hEE;
    @(posedge clk); #1;
    idle();
    n_cmp++;
    if (bus.ram_we !== 1'b1) begin
      n_err++;
      $display("FAIL run_inflight: we=%b want 1", bus.ram_we);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0 || bus.init_done !== 1'b0 || bus.ram_add_w !== 7'd0 || bus.ram_data_w !== 8'h00) begin
      n_err++;
      $display("FAIL run_rst: we=%b done=%b add=%0d data=%h want 0 0 0 00",
               bus.ram_we, bus.init_done, bus.ram_add_w, bus.ram_data_w);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[20] !== 8'h00) begin
      n_err++;
      $display("FAIL run_drop: mem[20]=%h want 00", mem[20]);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_init();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ram_we !== 1'b1 || bus.ram_add_w !== AW'(i)) begin
        n_err++;
        $display("FAIL reinit[%0d]: we=%b add=%0d want 1 %0d", i, bus.ram_we, bus.ram_add_w, i);
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0 || bus.init_done !== 1'b0 || bus.ram_add_w !== 7'd0) begin
      n_err++;
      $display("FAIL init_rst: we=%b done=%b add=%0d want 0 0 0", bus.ram_we, bus.init_done, bus.ram_add_w);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL init_rst_hold: we=%b want 0", bus.ram_we);
    end
  endtask

  // Entered with rst still high; the pending request is raised before release.
  task automatic test_pending_init();
    bus.req1_valid = 1'b1; bus.req1_addr = 7'd3; bus.req1_data = 8'h5C;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pend_rst_ready: rdy1=%b want 0", bus.req1_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ram_we !== 1'b1 || bus.ram_add_w !== AW'(i) || bus.ram_data_w !== 8'h00 ||
          bus.init_done !== (i == DEPTH-1) || bus.req1_ready !== (i == DEPTH-1)) begin
        n_err++;
        $display("FAIL pend_init[%0d]: we=%b add=%0d data=%h done=%b rdy1=%b want 1 %0d 00 %b %b",
                 i, bus.ram_we, bus.ram_add_w, bus.ram_data_w, bus.init_done, bus.req1_ready,
                 i, (i == DEPTH-1), (i == DEPTH-1));
      end
    end
    @(posedge clk); #1;
    idle();
    n_cmp++;
    if (bus.ram_we !== 1'b1 || bus.ram_add_w !== 7'd3 || bus.ram_data_w !== 8'h5C) begin
      n_err++;
      $display("FAIL pend_bus: we=%b add=%0d data=%h want 1 3 5c", bus.ram_we, bus.ram_add_w, bus.ram_data_w);
    end
    n_cmp++;
    if (mem[9] !== 8'h00 || mem[127] !== 8'h00) begin
      n_err++;
      $display("FAIL pend_reclear: mem[9]=%h mem[127]=%h want 00 00", mem[9], mem[127]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem[3] !== 8'h5C) begin
      n_err++;
      $display("FAIL pend_ram: mem[3]=%h want 5c", mem[3]);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_init_clear();
    test_single();
    test_alternate();
    test_same_addr();
    test_reset_mid_run();
    test_reset_mid_init();
    test_pending_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
